// File: rtl/fb_stream_pkg.sv
// Shared constants and state encoding for the fibre stream framer/deframer pair.
// K-codes and CRC parameters must match on both ends of the link.
package fb_stream_pkg;

    localparam int SHARED_MEM_AW = 32;
    localparam int FB_DW         = 32;
    localparam int FB_MAX_WORDS  = 16;

    localparam logic [7:0]  K28_5_IDLE = 8'hBC;
    localparam logic [7:0]  K28_2_SOP  = 8'h5C;
    localparam logic [7:0]  K28_1_EOP  = 8'h3C;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SOP,
        ST_HDR,
        ST_DATA,
        ST_EOP,
        ST_CRC_HI,
        ST_CRC_LO
    } fb_state_e;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle; master drives address/data/ready-for-response, slave the rest.
interface axi4_lite_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/crc16_ccitt_byte.sv
// Next CRC-16/CCITT (poly 0x1021, MSB first) after absorbing one byte.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module crc16_ccitt_byte
    import fb_stream_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_v;

    always_comb begin
        crc_v = crc_i ^ {byte_i, 8'h00};
        for (int i = 0; i < 8; i++) begin
            crc_v = crc_v[15] ? ((crc_v << 1) ^ CRC16_POLY) : (crc_v << 1);
        end
        crc_o = crc_v;
    end

endmodule

// File: rtl/stream_encoder_m.sv
// Fetches a block over AXI4-Lite reads, then emits SOP/len/data/EOP/CRC K-coded symbols.
// Latency: one symbol per tx_ena strobe once the whole block is buffered; fetch is unbounded.
// Backpressure: one AXI read outstanding; symbol output stalls whenever tx_ena is low.
module stream_encoder_m
    import fb_stream_pkg::*;
#(
    parameter int AW        = SHARED_MEM_AW,
    parameter int DW        = FB_DW,
    parameter int MAX_WORDS = FB_MAX_WORDS
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [7:0]    len,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          tx_ena,
    output logic [7:0]    tx_data,
    output logic          tx_isk,
    axi4_lite_if.master   axi
);

    localparam int BPW = DW / 8;
    localparam int BW  = $clog2(BPW);
    localparam int IW  = $clog2(MAX_WORDS);
    localparam int CW  = $clog2(MAX_WORDS + 1);

    fb_state_e     state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [AW-1:0] araddr_q, araddr_d;
    logic          ar_vld_q, ar_vld_d;
    logic          r_rdy_q, r_rdy_d;
    logic [CW-1:0] word_idx_q, word_idx_d;
    logic [BW-1:0] byte_idx_q, byte_idx_d;
    logic [DW-1:0] fbuf_q [MAX_WORDS];
    logic [DW-1:0] fbuf_d [MAX_WORDS];
    logic [15:0]   crc_q, crc_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_isk_q, tx_isk_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [7:0]    data_byte;
    logic [7:0]    crc_byte;
    logic [15:0]   crc_next;
    logic          last_word;
    logic          last_byte;

    assign data_byte = fbuf_q[word_idx_q[IW-1:0]][{byte_idx_q, 3'b000} +: 8];
    assign crc_byte  = (state_q == ST_HDR) ? len_q : data_byte;
    assign last_word = ((word_idx_q + CW'(1)) == len_q[CW-1:0]);
    assign last_byte = (byte_idx_q == BW'(BPW - 1));

    crc16_ccitt_byte u_crc (
        .crc_i  (crc_q),
        .byte_i (crc_byte),
        .crc_o  (crc_next)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        araddr_d   = araddr_q;
        ar_vld_d   = ar_vld_q;
        r_rdy_d    = r_rdy_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        fbuf_d     = fbuf_q;
        crc_d      = crc_q;
        tx_data_d  = tx_data_q;
        tx_isk_d   = tx_isk_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_ena) begin
                    tx_data_d = K28_5_IDLE;
                    tx_isk_d  = 1'b1;
                end
                if (start) begin
                    if (len > 8'(MAX_WORDS)) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d    = ST_FETCH;
                        busy_d     = 1'b1;
                        len_d      = len;
                        araddr_d   = base_addr;
                        ar_vld_d   = (len != 8'd0);
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        crc_d      = CRC16_INIT;
                    end
                end
            end
            ST_FETCH: begin
                // Idle fill keeps the link locked while memory is slow.
                if (tx_ena) begin
                    tx_data_d = K28_5_IDLE;
                    tx_isk_d  = 1'b1;
                end
                if (len_q == 8'd0) begin
                    state_d = ST_SOP;
                end
                if (ar_vld_q && axi.arready) begin
                    ar_vld_d = 1'b0;
                    r_rdy_d  = 1'b1;
                end
                if (r_rdy_q && axi.rvalid) begin
                    r_rdy_d = 1'b0;
                    if (axi.rresp != AXI_RESP_OKAY) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        fbuf_d[word_idx_q[IW-1:0]] = axi.rdata;
                        if (last_word) begin
                            state_d    = ST_SOP;
                            word_idx_d = '0;
                        end else begin
                            word_idx_d = word_idx_q + CW'(1);
                            araddr_d   = araddr_q + AW'(BPW);
                            ar_vld_d   = 1'b1;
                        end
                    end
                end
            end
            ST_SOP: if (tx_ena) begin
                tx_data_d = K28_2_SOP;
                tx_isk_d  = 1'b1;
                state_d   = ST_HDR;
            end
            ST_HDR: if (tx_ena) begin
                tx_data_d = len_q;
                tx_isk_d  = 1'b0;
                crc_d     = crc_next;
                state_d   = (len_q == 8'd0) ? ST_EOP : ST_DATA;
            end
            ST_DATA: if (tx_ena) begin
                tx_data_d = data_byte;
                tx_isk_d  = 1'b0;
                crc_d     = crc_next;
                if (last_byte) begin
                    byte_idx_d = '0;
                    if (last_word) begin
                        state_d = ST_EOP;
                    end else begin
                        word_idx_d = word_idx_q + CW'(1);
                    end
                end else begin
                    byte_idx_d = byte_idx_q + BW'(1);
                end
            end
            ST_EOP: if (tx_ena) begin
                tx_data_d = K28_1_EOP;
                tx_isk_d  = 1'b1;
                state_d   = ST_CRC_HI;
            end
            ST_CRC_HI: if (tx_ena) begin
                tx_data_d = crc_q[15:8];
                tx_isk_d  = 1'b0;
                state_d   = ST_CRC_LO;
            end
            ST_CRC_LO: if (tx_ena) begin
                tx_data_d = crc_q[7:0];
                tx_isk_d  = 1'b0;
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
                done_d    = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            araddr_q   <= '0;
            ar_vld_q   <= 1'b0;
            r_rdy_q    <= 1'b0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            fbuf_q     <= '{default: '0};
            crc_q      <= CRC16_INIT;
            tx_data_q  <= K28_5_IDLE;
            tx_isk_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            araddr_q   <= araddr_d;
            ar_vld_q   <= ar_vld_d;
            r_rdy_q    <= r_rdy_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            fbuf_q     <= fbuf_d;
            crc_q      <= crc_d;
            tx_data_q  <= tx_data_d;
            tx_isk_q   <= tx_isk_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign tx_data = tx_data_q;
    assign tx_isk  = tx_isk_q;

    assign axi.araddr  = araddr_q;
    assign axi.arvalid = ar_vld_q;
    assign axi.rready  = r_rdy_q;
    assign axi.awaddr  = '0;
    assign axi.awvalid = 1'b0;
    assign axi.wdata   = '0;
    assign axi.wstrb   = '0;
    assign axi.wvalid  = 1'b0;
    assign axi.bready  = 1'b0;

endmodule

// File: tb/tb_stream_encoder_m.sv
// Bench for stream_encoder_m: randomized AXI-Lite memory, strobe patterns and a byte-level frame/CRC model.
module tb_stream_encoder_m;
    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int MAXW = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          start = 1'b0;
    logic          tx_ena = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [7:0]    len = '0;
    logic          busy, done, err, tx_isk;
    logic [7:0]    tx_data;

    axi4_lite_if #(.AW(AW), .DW(DW)) axi_bus ();

    stream_encoder_m #(.AW(AW), .DW(DW), .MAX_WORDS(MAXW)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .tx_ena    (tx_ena),
        .tx_data   (tx_data),
        .tx_isk    (tx_isk),
        .axi       (axi_bus)
    );

    always #5 aclk = ~aclk;

    int passed = 0;
    int total  = 0;
    int ena_mode = 0;
    int err_rd_idx = -1;
    int rd_cnt = 0;
    int done_cnt = 0;

    logic [31:0]   mem [0:16383];
    logic [8:0]    sym_q[$];
    logic [8:0]    exp_q[$];
    logic [AW-1:0] ar_addr_q[$];
    logic [AW-1:0] exp_addr_q[$];

    // tx_ena pattern: 0 always on, 1 every other cycle, 2 random.
    initial begin
        forever begin
            @(negedge aclk);
            case (ena_mode)
                0:       tx_ena = 1'b1;
                1:       tx_ena = ~tx_ena;
                default: tx_ena = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin : monitor
        logic e;
        forever begin
            @(posedge aclk);
            e = tx_ena;
            #1;
            if (e) sym_q.push_back({tx_isk, tx_data});
            if (done) done_cnt++;
        end
    end

    initial begin : axi_slave
        bit            ar_fire, r_fire, pend;
        logic [AW-1:0] a_s, paddr;
        int            arw, rw, idx;
        axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b0; axi_bus.rdata = '0; axi_bus.rresp = '0;
        axi_bus.awready = 1'b0; axi_bus.wready = 1'b0; axi_bus.bvalid = 1'b0; axi_bus.bresp = '0;
        pend = 0; arw = 0; rw = 0; idx = 0; paddr = '0;
        forever begin
            @(negedge aclk);
            ar_fire = axi_bus.arvalid && axi_bus.arready;
            r_fire  = axi_bus.rvalid && axi_bus.rready;
            a_s     = axi_bus.araddr;
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b0; pend = 0;
                continue;
            end
            if (ar_fire) begin
                axi_bus.arready = 1'b0;
                pend = 1; paddr = a_s; idx = rd_cnt; rd_cnt++;
                ar_addr_q.push_back(a_s);
                rw = $urandom_range(0, 3); arw = $urandom_range(0, 3);
            end
            if (r_fire) axi_bus.rvalid = 1'b0;
            if (pend && !axi_bus.rvalid) begin
                if (rw == 0) begin
                    axi_bus.rvalid = 1'b1;
                    axi_bus.rdata  = mem[paddr[AW-1:2]];
                    axi_bus.rresp  = (idx == err_rd_idx) ? 2'b10 : 2'b00;
                    pend = 0;
                end else rw--;
            end
            if (axi_bus.arvalid && !axi_bus.arready && !pend) begin
                if (arw == 0) axi_bus.arready = 1'b1;
                else arw--;
            end
        end
    end

    // Bit-serial LFSR form of CRC-16/CCITT-FALSE.
    function automatic logic [15:0] crc_ref_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int k = 7; k >= 0; k--) begin
            fb = r[15] ^ b[k];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    task automatic build_expected(input logic [AW-1:0] base, input int n);
        logic [7:0]    bytes[$];
        logic [15:0]   c;
        logic [31:0]   w;
        logic [AW-1:0] a;
        exp_q.delete();
        exp_addr_q.delete();
        bytes.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            a = base + AW'(4 * i);
            exp_addr_q.push_back(a);
            w = mem[a[AW-1:2]];
            for (int b = 0; b < 4; b++) bytes.push_back(w[8*b +: 8]);
        end
        c = 16'hFFFF;
        foreach (bytes[k]) c = crc_ref_byte(c, bytes[k]);
        exp_q.push_back({1'b1, 8'h5C});
        foreach (bytes[k]) exp_q.push_back({1'b0, bytes[k]});
        exp_q.push_back({1'b1, 8'h3C});
        exp_q.push_back({1'b0, c[15:8]});
        exp_q.push_back({1'b0, c[7:0]});
    endtask

    function automatic int frame_start();
        for (int k = 0; k < sym_q.size(); k++) if (sym_q[k] !== 9'h1BC) return k;
        return -1;
    endfunction

    function automatic int sym_diff(input int s);
        if (s < 0) return 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (s + k >= sym_q.size()) return k;
            if (sym_q[s+k] !== exp_q[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [8:0] got_sym(input int idx);
        if (idx < 0 || idx >= sym_q.size()) return 9'h1FF;
        return sym_q[idx];
    endfunction

    function automatic int addr_diff();
        for (int k = 0; k < exp_addr_q.size(); k++) begin
            if (k >= ar_addr_q.size()) return k;
            if (ar_addr_q[k] !== exp_addr_q[k]) return k;
        end
        if (ar_addr_q.size() > exp_addr_q.size()) return exp_addr_q.size();
        return -1;
    endfunction

    task automatic clear_obs();
        sym_q.delete(); ar_addr_q.delete(); rd_cnt = 0; done_cnt = 0;
    endtask

    task automatic launch(input logic [AW-1:0] base, input logic [7:0] n);
        @(negedge aclk);
        base_addr = base; len = n; start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge aclk);
            #2;
            if (done) begin to = 1'b0; break; end
        end
    endtask

    task automatic wait_in_data(input int nsym);
        for (int c = 0; c < 4000; c++) begin
            @(posedge aclk);
            #2;
            if (frame_start() >= 0 && sym_q.size() > frame_start() + nsym) break;
        end
    endtask

    task automatic test_reset();
        int bad;
        ena_mode = 1;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        total++; if ({tx_isk, tx_data} !== 9'h1BC) $display("FAIL reset_tx got %h want 1bc", {tx_isk, tx_data}); else passed++;
        total++; if ({busy, done, err} !== 3'b000) $display("FAIL reset_status got %b want 000", {busy, done, err}); else passed++;
        total++; if ({axi_bus.arvalid, axi_bus.rready} !== 2'b00 || axi_bus.araddr !== '0)
            $display("FAIL reset_axi got arvalid=%b rready=%b araddr=%h want 0 0 0", axi_bus.arvalid, axi_bus.rready, axi_bus.araddr);
        else passed++;
        aresetn = 1'b1;
        clear_obs();
        repeat (20) @(negedge aclk);
        bad = 0;
        foreach (sym_q[k]) if (sym_q[k] !== 9'h1BC) bad++;
        total++; if (bad != 0 || sym_q.size() < 5) $display("FAIL idle_stream got %0d non-idle of %0d want 0 of >=5", bad, sym_q.size()); else passed++;
        total++; if (ar_addr_q.size() != 0 || axi_bus.arvalid !== 1'b0) $display("FAIL idle_axi got %0d reads want 0", ar_addr_q.size()); else passed++;
    endtask

    task automatic test_crc_model();
        string       s;
        logic [15:0] c;
        s = "123456789";
        c = 16'hFFFF;
        for (int i = 0; i < s.len(); i++) c = crc_ref_byte(c, s[i]);
        total++; if (c !== 16'h29B1) $display("FAIL crc_model got %h want 29b1", c); else passed++;
    endtask

    task automatic test_basic_frame();
        bit to; int s, d;
        mem[0] = 32'hDEADBEEF; mem[1] = 32'h5555AAAA; mem[2] = 32'h11112222; mem[3] = 32'h33334444;
        ena_mode = 0;
        build_expected('0, 4);
        clear_obs();
        launch('0, 8'd4);
        total++; if (busy !== 1'b1) $display("FAIL basic_busy_rise got %b want 1", busy); else passed++;
        wait_done(to);
        total++; if (to || err !== 1'b0) $display("FAIL basic_done got timeout=%b err=%b want 0 0", to, err); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL basic_busy_fall got %b want 0", busy); else passed++;
        s = frame_start(); d = sym_diff(s);
        total++; if (d != -1) $display("FAIL basic_stream sym %0d got %h want %h", d, got_sym(s + d), exp_q[d]); else passed++;
        d = addr_diff();
        total++; if (d != -1) $display("FAIL basic_araddr idx %0d got %0d reads want %0d", d, ar_addr_q.size(), exp_addr_q.size()); else passed++;
        repeat (3) @(negedge aclk);
        total++; if (got_sym(s + exp_q.size()) !== 9'h1BC) $display("FAIL basic_trail got %h want 1bc", got_sym(s + exp_q.size())); else passed++;
    endtask

    task automatic test_zero_len();
        bit to; int s, d;
        ena_mode = 2;
        build_expected(16'h0040, 0);
        clear_obs();
        launch(16'h0040, 8'd0);
        wait_done(to);
        total++; if (to || err !== 1'b0) $display("FAIL zero_done got timeout=%b err=%b want 0 0", to, err); else passed++;
        s = frame_start(); d = sym_diff(s);
        total++; if (d != -1) $display("FAIL zero_stream sym %0d got %h want %h", d, got_sym(s + d), exp_q[d]); else passed++;
        total++; if (ar_addr_q.size() != 0) $display("FAIL zero_no_ar got %0d reads want 0", ar_addr_q.size()); else passed++;
    endtask

    task automatic test_bad_len();
        ena_mode = 0;
        clear_obs();
        @(negedge aclk);
        base_addr = 16'h0100; len = 8'd17; start = 1'b1;
        @(posedge aclk);
        #1;
        total++; if ({done, err} !== 2'b11) $display("FAIL badlen_pulse got done=%b err=%b want 1 1", done, err); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL badlen_busy got %b want 0", busy); else passed++;
        @(negedge aclk);
        start = 1'b0;
        @(posedge aclk);
        #1;
        total++; if (done !== 1'b0) $display("FAIL badlen_one_cycle got %b want 0", done); else passed++;
        repeat (10) @(negedge aclk);
        total++; if (ar_addr_q.size() != 0 || frame_start() != -1)
            $display("FAIL badlen_silent got %0d reads, frame at %0d want 0, -1", ar_addr_q.size(), frame_start());
        else passed++;
    endtask

    task automatic test_slverr();
        bit to;
        ena_mode = 0;
        clear_obs();
        err_rd_idx = 2;
        launch(16'h0100, 8'd4);
        wait_done(to);
        total++; if (to || err !== 1'b1) $display("FAIL slverr_done got timeout=%b err=%b want 0 1", to, err); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL slverr_busy got %b want 0", busy); else passed++;
        repeat (6) @(negedge aclk);
        total++; if (frame_start() != -1) $display("FAIL slverr_no_sop got frame at %0d want none", frame_start()); else passed++;
        total++; if (ar_addr_q.size() != 3) $display("FAIL slverr_reads got %0d want 3", ar_addr_q.size()); else passed++;
        err_rd_idx = -1;
    endtask

    task automatic test_start_during_data();
        bit to; int s, d;
        ena_mode = 1;
        build_expected(16'h0200, 8);
        clear_obs();
        launch(16'h0200, 8'd8);
        wait_in_data(5);
        launch(16'h0300, 8'd3);
        wait_done(to);
        total++; if (to || err !== 1'b0) $display("FAIL ignstart_done got timeout=%b err=%b want 0 0", to, err); else passed++;
        s = frame_start(); d = sym_diff(s);
        total++; if (d != -1) $display("FAIL ignstart_stream sym %0d got %h want %h", d, got_sym(s + d), exp_q[d]); else passed++;
        repeat (8) @(negedge aclk);
        d = addr_diff();
        total++; if (d != -1 || done_cnt != 1) $display("FAIL ignstart_axi got reads=%0d dones=%0d want 8 1", ar_addr_q.size(), done_cnt); else passed++;
    endtask

    task automatic test_reset_mid();
        bit to; int s, d, bad, n;
        ena_mode = 0;
        build_expected(16'h0400, 6);
        clear_obs();
        launch(16'h0400, 8'd6);
        wait_in_data(8);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        total++; if ({tx_isk, tx_data} !== 9'h1BC || busy !== 1'b0)
            $display("FAIL midreset_out got %h busy=%b want 1bc 0", {tx_isk, tx_data}, busy);
        else passed++;
        @(negedge aclk);
        aresetn = 1'b1;
        sym_q.delete();
        repeat (6) @(negedge aclk);
        bad = 0;
        foreach (sym_q[k]) if (sym_q[k] !== 9'h1BC) bad++;
        total++; if (bad != 0 || sym_q.size() < 4 || busy !== 1'b0)
            $display("FAIL midreset_no_resume got %0d non-idle busy=%b want 0 0", bad, busy);
        else passed++;
        n = $urandom_range(1, MAXW);
        build_expected(16'h0500, n);
        clear_obs();
        launch(16'h0500, 8'(n));
        wait_done(to);
        s = frame_start(); d = sym_diff(s);
        total++; if (to || err !== 1'b0 || d != -1)
            $display("FAIL midreset_next got timeout=%b err=%b diff=%0d want 0 0 -1", to, err, d);
        else passed++;
    endtask

    task automatic test_back_to_back();
        bit to; int s, d, n;
        logic [AW-1:0] base;
        for (int it = 0; it < 6; it++) begin
            ena_mode = $urandom_range(0, 2);
            n = $urandom_range(0, MAXW);
            base = AW'({$urandom_range(0, 16383), 2'b00});
            if (it == 2) begin base = 16'hFFF0; n = 8; end
            build_expected(base, n);
            clear_obs();
            launch(base, 8'(n));
            wait_done(to);
            s = frame_start(); d = sym_diff(s);
            total++; if (to || err !== 1'b0 || d != -1)
                $display("FAIL b2b_frame%0d len=%0d got timeout=%b err=%b diff=%0d sym=%h want 0 0 -1", it, n, to, err, d, got_sym(s + d));
            else passed++;
            d = addr_diff();
            total++; if (d != -1) $display("FAIL b2b_araddr%0d idx %0d got %0d reads want %0d", it, d, ar_addr_q.size(), exp_addr_q.size()); else passed++;
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        test_reset();
        test_crc_model();
        test_basic_frame();
        test_zero_len();
        test_bad_len();
        test_slverr();
        test_start_during_data();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
